mskaes_kat_sequencer: RTL

Synthesizable known-answer-test engine for the masked AES-128 core wrapper. Reseeds the core PRNG, then streams NVEC unmasked (plaintext, key, expected ciphertext) vectors from an external ROM. Each vector is shared into d bit-interleaved shares and sent to the core; the returned ciphertext shares are recombined and compared. Reports per-run pass/fail, failure count, first failing index and per-vector latency. Replaces manual single-vector checking with an on-chip, multi-vector, timeout-guarded sequence.

---
 rtl/mskaes_kat_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mskaes_kat_sequencer.sv
// Known-answer-test sequencer for the masked AES-128 core: reseed the PRNG, stream NVEC vectors, recombine and compare.
// Build option RANDOM_SHARING_EN: LFSR-generated shares 1..d-1 replace the all-zero upper shares.
module mskaes_kat_sequencer #(
    parameter int d       = 2,
    parameter int NVEC    = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16,
    parameter int IW      = (NVEC > 1) ? $clog2(NVEC) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic [IW-1:0]      vec_idx_o,
    input  logic [127:0]       vec_pt_i,
    input  logic [127:0]       vec_key_i,
    input  logic [127:0]       vec_ct_i,
    output logic               prng_start_reseed_o,
    input  logic               prng_out_valid_i,
    output logic               valid_in_o,
    input  logic               ready_i,
    output logic [128*d-1:0]   sh_plaintext_o,
    output logic [128*d-1:0]   sh_key_o,
    input  logic               cipher_valid_i,
    input  logic [128*d-1:0]   sh_ciphertext_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_all_o,
    output logic [IW:0]        fail_count_o,
    output logic [IW-1:0]      first_fail_idx_o,
    output logic [CW-1:0]      last_cycles_o,
    output logic               timeout_err_o
);
    // IDLE wait start | RESEED reseed pulse | WAIT_PRNG wait prng | LOAD share+offer | RUN await ct | CHECK compare | DONE report
    localparam logic [2:0] S_IDLE = 3'd0, S_RESEED = 3'd1, S_WAIT_PRNG = 3'd2, S_LOAD = 3'd3,
                           S_RUN = 3'd4, S_CHECK = 3'd5, S_DONE = 3'd6;
    localparam logic [CW-1:0] TMO_CNT  = CW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, first_q, first_d;
    logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
    logic [IW:0]       fail_q, fail_d, fail_inc;
    logic [CW-1:0]     cnt_q, cnt_d, last_q, last_d;
    logic [127:0]      ct_q, ct_d, ct_rec;
    logic [128*d-1:0]  shpt_q, shpt_d, shkey_q, shkey_d, shpt_new, shkey_new;

    always_comb begin
        ct_rec = '0;
        for (int i = 0; i < 128; i++) ct_rec[i] = ^sh_ciphertext_i[d*i +: d];
    end

`ifdef RANDOM_SHARING_EN
    logic [31:0] lfsr_q;
    logic        pt_mask, key_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 32'hACE1_2468;
        else       lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    // Each share position taps a different LFSR rotation; share 0 absorbs the XOR of the others.
    always_comb begin
        shpt_new  = '0;
        shkey_new = '0;
        pt_mask   = 1'b0;
        key_mask  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            pt_mask  = 1'b0;
            key_mask = 1'b0;
            for (int j = 1; j < d; j++) begin
                shpt_new[d*i+j]  = lfsr_q[5'((i + 7*j) % 32)];
                shkey_new[d*i+j] = lfsr_q[5'((i + 7*j + 13) % 32)];
                pt_mask  = pt_mask ^ lfsr_q[5'((i + 7*j) % 32)];
                key_mask = key_mask ^ lfsr_q[5'((i + 7*j + 13) % 32)];
            end
            shpt_new[d*i]  = vec_pt_i[i] ^ pt_mask;
            shkey_new[d*i] = vec_key_i[i] ^ key_mask;
        end
    end
`else
    always_comb begin
        shpt_new  = '0;
        shkey_new = '0;
        for (int i = 0; i < 128; i++) begin
            shpt_new[d*i]  = vec_pt_i[i];
            shkey_new[d*i] = vec_key_i[i];
        end
    end
`endif

    assign fail_inc = (&fail_q) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ct_d    = ct_q;
        shpt_d  = shpt_q;
        shkey_d = shkey_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RESEED;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    fail_d  = '0;
                    first_d = '0;
                    last_d  = '0;
                    idx_d   = '0;
                end
            end
            S_RESEED:    state_d = S_WAIT_PRNG;
            S_WAIT_PRNG: if (prng_out_valid_i) state_d = S_LOAD;
            S_LOAD: begin
                if (!valid_q) begin
                    shpt_d  = shpt_new;
                    shkey_d = shkey_new;
                    valid_d = 1'b1;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = CW'(1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cipher_valid_i) begin
                    last_d  = cnt_q;
                    ct_d    = ct_rec;
                    state_d = S_CHECK;
                end else if (cnt_q == TMO_CNT) begin
                    tmo_d   = 1'b1;
                    fail_d  = fail_inc;
                    if (fail_q == '0) first_d = idx_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (ct_q != vec_ct_i) begin
                    fail_d = fail_inc;
                    if (fail_q == '0) first_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            fail_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            ct_q    <= '0;
            shpt_q  <= '0;
            shkey_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ct_q    <= ct_d;
            shpt_q  <= shpt_d;
            shkey_q <= shkey_d;
        end
    end

    assign vec_idx_o           = idx_q;
    assign prng_start_reseed_o = (state_q == S_RESEED);
    assign valid_in_o          = valid_q;
    assign sh_plaintext_o      = shpt_q;
    assign sh_key_o            = shkey_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign pass_all_o          = done_q && (fail_q == '0) && !tmo_q;
    assign fail_count_o        = fail_q;
    assign first_fail_idx_o    = first_q;
    assign last_cycles_o       = last_q;
    assign timeout_err_o       = tmo_q;
endmodule
